// File: rtl/axi_stream_pkg.sv
// Shared types and byte-count helpers for the AXI-Stream header stages.
// Helpers work on a fixed maximum lane count; callers size-cast to their own width.
package axi_stream_pkg;

  localparam int MAX_BYTES = 128;
  localparam int IDX_WD    = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // MSB-aligned thermometer: for nbytes lanes, bit nbytes-1 is byte 0.
  function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int cnt, input int nbytes);
    logic [MAX_BYTES-1:0] keep;
    keep = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes && i < cnt) keep[IDX_WD'(nbytes - 1 - i)] = 1'b1;
    end
    return keep;
  endfunction

  function automatic int keep_to_count(input logic [MAX_BYTES-1:0] keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic int clamp_strip(input int len, input int nbytes);
    return (len > nbytes) ? nbytes : len;
  endfunction

endpackage

// File: rtl/axi_stream_extract_header_if.sv
// Bundles the input stream, strip-count, header and payload handshakes of the
// header-extraction stage; slave is the DUT side, master the driving side.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);

  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;

  logic                    valid_strip;
  logic                    ready_strip;
  logic [BYTE_CNT_WD:0]    strip_len;

  logic                    valid_hdr;
  logic                    ready_hdr;
  logic [DATA_WD-1:0]      data_hdr;
  logic [DATA_BYTE_WD-1:0] keep_hdr;

  logic                    valid_out;
  logic                    ready_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    empty_pkt;

  modport slave (
    input  valid_in, data_in, keep_in, last_in, valid_strip, strip_len, ready_hdr, ready_out,
    output ready_in, ready_strip, valid_hdr, data_hdr, keep_hdr,
           valid_out, data_out, keep_out, last_out, empty_pkt
  );

  modport master (
    output valid_in, data_in, keep_in, last_in, valid_strip, strip_len, ready_hdr, ready_out,
    input  ready_in, ready_strip, valid_hdr, data_hdr, keep_hdr,
           valid_out, data_out, keep_out, last_out, empty_pkt
  );

endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips a per-packet count of leading bytes into a header beat and re-aligns
// the remaining payload so its first byte lands in the MSB lane.
module axi_stream_extract_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                         clk,
  input logic                         rst_n,
  axi_stream_extract_header_if.slave  bus
);

  localparam int            CW       = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_BYTE_WD);

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] mask;
    for (int i = 0; i < DATA_BYTE_WD; i++) mask[i*8 +: 8] = {8{keep[i]}};
    return mask;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CW-1:0] cnt);
    return DATA_BYTE_WD'(cnt_to_keep(int'(cnt), DATA_BYTE_WD));
  endfunction

  state_e                  r_state;
  logic [CW-1:0]           r_s;
  logic [CW-1:0]           r_flush_cnt;
  logic [DATA_WD-1:0]      r_res;
  logic                    r_valid_hdr;
  logic [DATA_WD-1:0]      r_data_hdr;
  logic [DATA_BYTE_WD-1:0] r_keep_hdr;
  logic                    r_valid_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_last_out;
  logic                    r_empty_pkt;

  logic                    w_hdr_free;
  logic                    w_out_free;
  logic                    w_ready_in;
  logic                    w_accept;
  logic [CW-1:0]           w_in_cnt;
  logic [CW-1:0]           w_s_new;
  logic [CW-1:0]           w_s_cur;
  logic [CW-1:0]           w_r_cnt;
  logic [CW-1:0]           w_hdr_cnt;
  logic [CW-1:0]           w_tail_cnt;
  logic [DATA_WD-1:0]      w_din;
  logic [DATA_WD-1:0]      w_shl;
  logic [DATA_WD-1:0]      w_merge;
  state_e                  w_nxt_state;
  logic                    w_ld_out;
  logic [DATA_WD-1:0]      w_ld_data;
  logic [CW-1:0]           w_ld_cnt;
  logic [DATA_BYTE_WD-1:0] w_ld_keep;
  logic                    w_ld_last;
  logic                    w_ld_res;
  logic                    w_ld_hdr;
  logic                    w_ld_empty;

  always_comb begin
    w_hdr_free = !r_valid_hdr || bus.ready_hdr;
    w_out_free = !r_valid_out || bus.ready_out;
    // NOTE: every combinational output is given a default first so no latch is inferred.
    w_ready_in = 1'b0;
    case (r_state)
      IDLE:    w_ready_in = bus.valid_strip && w_hdr_free && w_out_free;
      BODY:    w_ready_in = w_out_free;
      default: w_ready_in = 1'b0;
    endcase
    w_accept   = bus.valid_in && w_ready_in;

    w_in_cnt   = CW'(keep_to_count(MAX_BYTES'(bus.keep_in)));
    w_s_new    = CW'(clamp_strip(int'(bus.strip_len), DATA_BYTE_WD));
    w_s_cur    = (r_state == IDLE) ? w_s_new : r_s;
    w_r_cnt    = FULL_CNT - r_s;
    w_hdr_cnt  = (w_in_cnt < w_s_new) ? w_in_cnt : w_s_new;
    w_tail_cnt = w_in_cnt - w_s_cur;

    // Residual is kept MSB-aligned; merging drops the current beat in behind it.
    w_din      = bus.data_in & lane_mask(bus.keep_in);
    w_shl      = w_din << {w_s_cur, 3'b000};
    w_merge    = r_res | (w_din >> {w_r_cnt, 3'b000});

    w_nxt_state = r_state;
    w_ld_out    = 1'b0;
    w_ld_data   = w_merge;
    w_ld_cnt    = FULL_CNT;
    w_ld_last   = 1'b0;
    w_ld_res    = 1'b0;
    w_ld_hdr    = 1'b0;
    w_ld_empty  = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_ld_hdr = (w_s_new != '0);
        if (!bus.last_in) begin
          w_ld_res    = 1'b1;
          w_nxt_state = BODY;
        end else if (w_in_cnt <= w_s_new) begin
          w_ld_empty  = 1'b1;
        end else begin
          w_ld_out    = 1'b1;
          w_ld_data   = w_shl;
          w_ld_cnt    = w_tail_cnt;
          w_ld_last   = 1'b1;
        end
      end
      BODY: if (w_accept) begin
        w_ld_res = 1'b1;
        w_ld_out = 1'b1;
        if (bus.last_in) begin
          if (w_in_cnt <= r_s) begin
            w_ld_cnt    = w_r_cnt + w_in_cnt;
            w_ld_last   = 1'b1;
            w_nxt_state = IDLE;
          end else begin
            w_nxt_state = FLUSH;
          end
        end
      end
      FLUSH: if (w_out_free) begin
        w_ld_out    = 1'b1;
        w_ld_data   = r_res;
        w_ld_cnt    = r_flush_cnt;
        w_ld_last   = 1'b1;
        w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
    w_ld_keep = keep_of(w_ld_cnt);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: data/keep and residual registers are reset as well so outputs read zero out of reset.
      r_state     <= IDLE;
      r_s         <= '0;
      r_flush_cnt <= '0;
      r_res       <= '0;
      r_valid_hdr <= 1'b0;
      r_data_hdr  <= '0;
      r_keep_hdr  <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_keep_out  <= '0;
      r_last_out  <= 1'b0;
      r_empty_pkt <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_empty_pkt <= w_ld_empty;
      if (w_accept && r_state == IDLE) r_s <= w_s_new;
      if (w_ld_res) begin
        r_res       <= w_shl;
        r_flush_cnt <= w_tail_cnt;
      end
      if (w_ld_hdr) begin
        r_valid_hdr <= 1'b1;
        r_data_hdr  <= w_din & lane_mask(keep_of(w_hdr_cnt));
        r_keep_hdr  <= keep_of(w_hdr_cnt);
      end else if (bus.ready_hdr) begin
        r_valid_hdr <= 1'b0;
      end
      if (w_ld_out) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_ld_data & lane_mask(w_ld_keep);
        r_keep_out  <= w_ld_keep;
        r_last_out  <= w_ld_last;
      end else if (bus.ready_out) begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign bus.ready_in    = w_ready_in;
  assign bus.ready_strip = w_accept && (r_state == IDLE);
  assign bus.valid_hdr   = r_valid_hdr;
  assign bus.data_hdr    = r_data_hdr;
  assign bus.keep_hdr    = r_keep_hdr;
  assign bus.valid_out   = r_valid_out;
  assign bus.data_out    = r_data_out;
  assign bus.keep_out    = r_keep_out;
  assign bus.last_out    = r_last_out;
  assign bus.empty_pkt   = r_empty_pkt;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Table-driven bench for axi_stream_extract_header: packets from a vector table,
// expected header/payload beats checked through scoreboard queues.
module tb_axi_stream_extract_header;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    logic [2:0]       strip;
    int               nb;
    logic [0:3][31:0] d;
    logic [0:3][3:0]  k;
    logic             hv;
    logic [31:0]      hd;
    logic [3:0]       hk;
    int               no;
    logic [0:3][31:0] od;
    logic [0:3][3:0]  ok;
    logic             empty;
  } vec_t;

  localparam int N_VEC  = 11;
  localparam int N_LOOP = 10;

  vec_t  vecs [N_VEC];
  beat_t hdr_q[$];
  beat_t out_q[$];

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks   = 0;
  int          n_errors   = 0;
  int          empty_seen = 0;
  int          exp_empty  = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_d = '0;

  axi_stream_extract_header_if #(.DATA_WD(32)) bus ();

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare every beat the DUT hands over, and hold-stability under stall.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n) begin
      if (bus.valid_hdr && bus.ready_hdr) begin
        if (hdr_q.size() == 0) check("hdr_unexpected_valid", 32'(bus.valid_hdr), 32'd0);
        else begin
          e = hdr_q.pop_front();
          check("hdr_data", bus.data_hdr, e.d);
          check("hdr_keep", 32'(bus.keep_hdr), 32'(e.k));
        end
      end
      if (bus.valid_out && bus.ready_out) begin
        if (out_q.size() == 0) check("out_unexpected_valid", 32'(bus.valid_out), 32'd0);
        else begin
          e = out_q.pop_front();
          check("out_data", bus.data_out, e.d);
          check("out_keep", 32'(bus.keep_out), 32'(e.k));
          check("out_last", 32'(bus.last_out), 32'(e.l));
        end
      end
      if (bus.valid_out && !bus.ready_out) begin
        if (held_v) check("out_stable_under_stall", bus.data_out, held_d);
        held_v = 1'b1;
        held_d = bus.data_out;
      end else begin
        held_v = 1'b0;
      end
      if (bus.empty_pkt) empty_seen++;
    end
  end

  task automatic send_pkt(input int idx, input bit push);
    vec_t v;
    bit   acc;
    int   budget;
    v = vecs[idx];
    if (push) begin
      if (v.hv) hdr_q.push_back('{d: v.hd, k: v.hk, l: 1'b0});
      for (int i = 0; i < v.no; i++)
        out_q.push_back('{d: v.od[2'(i)], k: v.ok[2'(i)], l: (i == v.no - 1)});
      if (v.empty) exp_empty++;
    end
    bus.strip_len = v.strip;
    for (int b = 0; b < v.nb; b++) begin
      bus.valid_in    = 1'b1;
      bus.valid_strip = (b == 0);
      bus.data_in     = v.d[2'(b)];
      bus.keep_in     = v.k[2'(b)];
      bus.last_in     = (b == v.nb - 1);
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = bus.ready_in;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        check("beat_accept_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    bus.valid_in    = 1'b0;
    bus.valid_strip = 1'b0;
    bus.last_in     = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((hdr_q.size() != 0 || out_q.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("drain_queue_depth", 32'(hdr_q.size() + out_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("empty_pkt_count", 32'(empty_seen), 32'(exp_empty));
  endtask

  task automatic stall_out();
    int t;
    t = 0;
    while (!bus.valid_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.valid_out) check("stall_wait_valid_out", 32'(bus.valid_out), 32'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      check("stall_ready_in", 32'(bus.ready_in), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.ready_out = 1'b1;
  endtask

  initial begin
    int t;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.valid_strip = 1'b0; bus.strip_len = '0;
    bus.ready_hdr = 1'b0; bus.ready_out = 1'b0;

    vecs[0]  = '{strip: 3'd2, nb: 2, d: {32'hAABBCCDD, 32'h11223344, 32'h0, 32'h0}, k: {4'hF, 4'hF, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'hAABB0000, hk: 4'hC,
                 no: 2, od: {32'hCCDD1122, 32'h33440000, 32'h0, 32'h0}, ok: {4'hF, 4'hC, 4'h0, 4'h0}, empty: 1'b0};
    vecs[1]  = '{strip: 3'd1, nb: 2, d: {32'hA1B2C3D4, 32'hE5F60000, 32'h0, 32'h0}, k: {4'hF, 4'hC, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'hA1000000, hk: 4'h8,
                 no: 2, od: {32'hB2C3D4E5, 32'hF6000000, 32'h0, 32'h0}, ok: {4'hF, 4'h8, 4'h0, 4'h0}, empty: 1'b0};
    vecs[2]  = '{strip: 3'd3, nb: 1, d: {32'hCAFEBABE, 32'h0, 32'h0, 32'h0}, k: {4'hC, 4'h0, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'hCAFE0000, hk: 4'hC,
                 no: 0, od: '0, ok: '0, empty: 1'b1};
    vecs[3]  = '{strip: 3'd0, nb: 1, d: {32'h12345678, 32'h0, 32'h0, 32'h0}, k: {4'hF, 4'h0, 4'h0, 4'h0},
                 hv: 1'b0, hd: 32'h0, hk: 4'h0,
                 no: 1, od: {32'h12345678, 32'h0, 32'h0, 32'h0}, ok: {4'hF, 4'h0, 4'h0, 4'h0}, empty: 1'b0};
    vecs[4]  = '{strip: 3'd3, nb: 3, d: {32'h00112233, 32'h44556677, 32'h8899AABB, 32'h0}, k: {4'hF, 4'hF, 4'hF, 4'h0},
                 hv: 1'b1, hd: 32'h00112200, hk: 4'hE,
                 no: 3, od: {32'h33445566, 32'h778899AA, 32'hBB000000, 32'h0}, ok: {4'hF, 4'hF, 4'h8, 4'h0}, empty: 1'b0};
    vecs[5]  = '{strip: 3'd3, nb: 2, d: {32'hDEADBEEF, 32'h01020300, 32'h0, 32'h0}, k: {4'hF, 4'hE, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'hDEADBE00, hk: 4'hE,
                 no: 1, od: {32'hEF010203, 32'h0, 32'h0, 32'h0}, ok: {4'hF, 4'h0, 4'h0, 4'h0}, empty: 1'b0};
    vecs[6]  = '{strip: 3'd0, nb: 2, d: {32'h11111111, 32'h22220000, 32'h0, 32'h0}, k: {4'hF, 4'hC, 4'h0, 4'h0},
                 hv: 1'b0, hd: 32'h0, hk: 4'h0,
                 no: 2, od: {32'h11111111, 32'h22220000, 32'h0, 32'h0}, ok: {4'hF, 4'hC, 4'h0, 4'h0}, empty: 1'b0};
    vecs[7]  = '{strip: 3'd7, nb: 2, d: {32'h01020304, 32'h05060708, 32'h0, 32'h0}, k: {4'hF, 4'hE, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'h01020304, hk: 4'hF,
                 no: 1, od: {32'h05060700, 32'h0, 32'h0, 32'h0}, ok: {4'hE, 4'h0, 4'h0, 4'h0}, empty: 1'b0};
    vecs[8]  = '{strip: 3'd4, nb: 1, d: {32'h89ABCDEF, 32'h0, 32'h0, 32'h0}, k: {4'hF, 4'h0, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'h89ABCDEF, hk: 4'hF,
                 no: 0, od: '0, ok: '0, empty: 1'b1};
    vecs[9]  = '{strip: 3'd1, nb: 1, d: {32'h7F123456, 32'h0, 32'h0, 32'h0}, k: {4'h8, 4'h0, 4'h0, 4'h0},
                 hv: 1'b1, hd: 32'h7F000000, hk: 4'h8,
                 no: 0, od: '0, ok: '0, empty: 1'b1};
    vecs[10] = '{strip: 3'd1, nb: 3, d: {32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'h0}, k: {4'hF, 4'hF, 4'hF, 4'h0},
                 hv: 1'b1, hd: 32'h10000000, hk: 4'h8,
                 no: 3, od: {32'h20304050, 32'h60708090, 32'hA0B0C000, 32'h0}, ok: {4'hF, 4'hF, 4'hE, 4'h0}, empty: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_valid_hdr", 32'(bus.valid_hdr), 32'd0);
    check("rst_data_out",  bus.data_out,       32'd0);
    check("rst_keep_out",  32'(bus.keep_out),  32'd0);
    check("rst_last_out",  32'(bus.last_out),  32'd0);
    check("rst_empty_pkt", 32'(bus.empty_pkt), 32'd0);
    check("rst_data_hdr",  bus.data_hdr,       32'd0);
    check("rst_keep_hdr",  32'(bus.keep_hdr),  32'd0);
    @(posedge clk);
    #1;
    bus.ready_hdr = 1'b1;
    bus.ready_out = 1'b1;

    for (int i = 0; i < N_LOOP; i++) begin
      send_pkt(i, 1'b1);
      drain();
    end

    // Payload backpressure mid-packet, header left pending
    bus.ready_out = 1'b0;
    bus.ready_hdr = 1'b0;
    fork
      send_pkt(10, 1'b1);
      stall_out();
    join
    t = 0;
    while (out_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("bp_out_drained", 32'(out_q.size()), 32'd0);
    check("bp_hdr_pending", 32'(bus.valid_hdr), 32'd1);

    // Next packet offered while the header is still pending must not be taken
    bus.strip_len   = 3'd2;
    bus.valid_in    = 1'b1;
    bus.valid_strip = 1'b1;
    bus.data_in     = 32'hAABBCCDD;
    bus.keep_in     = 4'hF;
    bus.last_in     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("blocked_ready_in",    32'(bus.ready_in),    32'd0);
      check("blocked_ready_strip", 32'(bus.ready_strip), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.ready_hdr = 1'b1;
    send_pkt(0, 1'b1);
    drain();

    // Reset while in FLUSH
    bus.ready_out = 1'b0;
    bus.ready_hdr = 1'b0;
    send_pkt(0, 1'b0);
    check("flush_valid_out", 32'(bus.valid_out), 32'd1);
    check("flush_ready_in",  32'(bus.ready_in),  32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("post_rst_valid_hdr", 32'(bus.valid_hdr), 32'd0);
    check("post_rst_empty_pkt", 32'(bus.empty_pkt), 32'd0);
    @(posedge clk);
    #1;
    bus.ready_out = 1'b1;
    bus.ready_hdr = 1'b1;
    send_pkt(0, 1'b1);
    drain();

    // Pass-through beat appears right after the accepting edge
    send_pkt(3, 1'b1);
    @(negedge clk);
    check("passthru_latency", 32'(bus.valid_out), 32'd1);
    check("passthru_no_hdr",  32'(bus.valid_hdr), 32'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

Downstream counterpart of the header-insertion stage. Consumes one AXI-Stream packet and strips a per-packet count of leading bytes (0..DATA_BYTE_WD). The stripped bytes go out as a single header beat on a side port. The remaining payload is re-aligned so that the first payload byte sits in the MSB lane of the first output beat.

## Interface
Parameters
- DATA_WD, 32, stream data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-index width; strip count uses BYTE_CNT_WD+1 bits

Ports
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- valid_in / ready_in  in / out  1  input beat handshake
- data_in  in  DATA_WD  input data; byte 0 = data_in[DATA_WD-1 -: 8]
- keep_in  in  DATA_BYTE_WD  byte enables, MSB = byte 0
- last_in  in  1  final beat of packet
- valid_strip / ready_strip  in / out  1  per-packet strip-count handshake
- strip_len  in  BYTE_CNT_WD+1  bytes to strip; values >DATA_BYTE_WD clamp to DATA_BYTE_WD
- valid_hdr / ready_hdr  out / in  1  header beat handshake
- data_hdr  out  DATA_WD  stripped bytes, MSB-aligned, unused lanes zero
- keep_hdr  out  DATA_BYTE_WD  MSB-contiguous enables of the stripped bytes
- valid_out / ready_out  out / in  1  payload handshake
- data_out  out  DATA_WD  re-aligned payload, unused lanes zero
- keep_out  out  DATA_BYTE_WD  MSB-contiguous enables
- last_out  out  1  final payload beat
- empty_pkt  out  1  one-cycle pulse: packet carried no payload bytes

## Operation
- **Input rules**
  - Non-last input beats carry keep_in all ones.
  - Last beats carry an MSB-contiguous keep_in with n≥1 valid bytes.
- **States**
  - IDLE: waits for the first beat. The first beat is accepted only when all of these hold:
    - valid_in and valid_strip are high;
    - the header register is free (!valid_hdr || ready_hdr);
    - the output register is free (!valid_out || ready_out).
    - On acceptance, ready_strip = 1 in the same cycle, and strip_len is latched as s.
  - BODY: streams the remaining beats.
  - FLUSH: emits one trailing beat; ready_in = 0.
- **First beat (n bytes valid)**
  - Header gets the top min(n,s) bytes.
  - If s=0, no header beat is produced.
  - If first beat is last and n≤s: no payload beats; empty_pkt pulses; return to IDLE.
  - If first beat is last and n>s: one payload beat of n−s bytes, last_out=1; go to IDLE.
  - Otherwise: residual register loads the low r=DATA_BYTE_WD−s bytes; go to BODY.
- **BODY**
  - Each accepted beat emits {residual r bytes, top s bytes of current beat}.
  - The low r bytes of the current beat are loaded into the residual register.
  - On last_in with n bytes:
    - n≤s: emit a single last beat of r+n bytes; go to IDLE.
    - n>s: emit a full beat; go to FLUSH.
- **FLUSH**
  - Emit the n−s byte last beat; go to IDLE when it is accepted.
- **s=0:** behaves as pass-through, delayed by one beat inside a multi-beat packet (residual holds a full beat).
- **Byte count/keep**
  - Counts are formed on BYTE_CNT_WD+1 bits.
  - keep = MSB-aligned thermometer of the count.
  - Data lanes outside keep are forced to zero.

## Timing
- Reset values: all valids, last_out, empty_pkt = 0; data/keep outputs = 0; state IDLE; residual cleared.
- Output registers update one cycle after input acceptance; data/keep/last stay stable while valid && !ready.
- ready_in:
  - BODY: !valid_out || ready_out.
  - FLUSH: 0.
  - IDLE: as above.
- ready_in must not depend on valid_in.
- Full throughput with ready_out held high; a FLUSH adds one cycle per packet.
- Header and payload ports are independent, except that a pending header blocks the next packet's first beat.
- Reset mid-packet discards the packet; the next packet after release is processed cleanly.

## Structure
- Shared package axi_stream_pkg holds:
  - state enum IDLE/BODY/FLUSH;
  - count-to-keep (MSB-aligned) function;
  - keep-to-count function;
  - strip_len clamp function.
- Single flat module; no sub-module. Output, header and residual registers live inline.

## Test plan
- **Basic strip (s=2):**
  - Stimulus: input 0xAABBCCDD/1111, then 0x11223344/1111 last.
  - Expected: header 0xAABB0000/1100; payload 0xCCDD1122/1111, then 0x33440000/1100 last (FLUSH taken).
- **Partial last beat (s=1):**
  - Stimulus: input 0xA1B2C3D4/1111, then 0xE5F60000/1100 last.
  - Expected: header 0xA1000000/1000; payload 0xB2C3D4E5/1111, then 0xF6000000/1000 last.
- **Short packet (s=3):**
  - Stimulus: single beat 0xCAFEBABE/1100 last.
  - Expected: header 0xCAFE0000/1100; no payload beat; empty_pkt pulses once.
- **Pass-through (s=0):**
  - Stimulus: single beat 0x12345678/1111 last.
  - Expected: payload 0x12345678/1111 last one cycle later; valid_hdr stays 0.
- **Backpressure:**
  - Stimulus: ready_out=0 for 3 cycles mid-packet; ready_hdr=0 while the next packet is offered.
  - Expected: data_out held stable; ready_in=0; next first beat not accepted; no beat lost or duplicated.
- **Reset in FLUSH:**
  - Stimulus: assert rst_n=0 for one edge while in FLUSH.
  - Expected: all valids 0 after that edge; a following s=2 packet yields correct header and payload.
